// File: rtl/synth_pkg.sv
// Shared constants and the envelope state type for the synth voice blocks.
package synth_pkg;

  localparam int unsigned SAMPLE_DIV = 1024;
  localparam int          FREQ_W     = 24;
  localparam int          VEL_W      = 7;
  localparam int          ENV_W      = 14;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } env_state_t;

  // Velocity becomes the integer part of the 7.7 envelope level.
  function automatic logic [ENV_W-1:0] vel_target(input logic [VEL_W-1:0] v);
    return {v, {(ENV_W-VEL_W){1'b0}}};
  endfunction

endpackage

// File: rtl/note_env.sv
// Linear attack/sustain/release envelope; all updates happen on sample ticks.
module note_env
  import synth_pkg::*;
#(
  parameter int unsigned ATTACK_RATE  = 64,
  parameter int unsigned RELEASE_RATE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             play,
  input  logic [VEL_W-1:0] vel,
  output logic [ENV_W-1:0] env,
  output env_state_t       state,
  output logic             restart
);

  env_state_t       next_state;
  logic [ENV_W-1:0] next_env;
  logic [ENV_W-1:0] target;
  logic [ENV_W:0]   env_up;
  logic             note_on;

  // Velocity 0 with play held is a note-off, as in MIDI running status.
  assign note_on = play && (vel != '0);
  assign target  = vel_target(vel);
  assign env_up  = {1'b0, env} + (ENV_W+1)'(ATTACK_RATE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      env   <= '0;
    end else if (tick) begin
      // NOTE: non-blocking so state and env both update from pre-edge values.
      state <= next_state;
      env   <= next_env;
    end
  end

  always_comb begin
    // NOTE: defaults first; any path that skips an assignment holds, no latch.
    next_state = state;
    next_env   = env;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (note_on) begin
          next_state = ATTACK;
          restart    = tick;
        end
      end
      ATTACK: begin
        if (!note_on) begin
          next_state = RELEASE;
        end else if (env_up >= {1'b0, target}) begin
          // Also covers a velocity drop below the current level.
          next_env   = target;
          next_state = SUSTAIN;
        end else begin
          next_env = env_up[ENV_W-1:0];
        end
      end
      SUSTAIN: begin
        if (!note_on) next_state = RELEASE;
        else          next_env   = target;
      end
      RELEASE: begin
        if (note_on) begin
          next_state = ATTACK;
        end else if (env <= ENV_W'(RELEASE_RATE)) begin
          next_env   = '0;
          next_state = IDLE;
        end else begin
          next_env = env - ENV_W'(RELEASE_RATE);
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/note_voice.sv
// Single-voice DDS tone generator scaled by an ADSR-style envelope.
// Define NOTE_VOICE_TRIANGLE_EN for a triangle wave instead of the default saw.
module note_voice
  import synth_pkg::FREQ_W;
  import synth_pkg::VEL_W;
  import synth_pkg::ENV_W;
  import synth_pkg::env_state_t;
  import synth_pkg::IDLE;
#(
  parameter int unsigned SAMPLE_DIV   = synth_pkg::SAMPLE_DIV,
  parameter int unsigned INC_K        = 90072,
  parameter int unsigned INC_SHIFT    = 10,
  parameter int unsigned ATTACK_RATE  = 64,
  parameter int unsigned RELEASE_RATE = 16
) (
  input  logic                CLK_50MHZ,
  input  logic                RST,
  input  logic [FREQ_W-1:0]   freq,
  input  logic [VEL_W-1:0]    vel,
  input  logic                play,
  output logic signed [15:0]  sample,
  output logic                sample_stb,
  output logic                active
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int K_W    = $clog2(INC_K + 1);
  localparam int PROD_W = FREQ_W + K_W;
  localparam int MUL_W  = 16 + ENV_W + 1;
  // Keeps only the integer part of env; scaling by it then shifting by ENV_W
  // equals (wave * env[13:7]) >>> 7.
  localparam logic [ENV_W-1:0] AMP_MASK = ~ENV_W'((1 << (ENV_W - VEL_W)) - 1);

  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;
  logic [PROD_W-1:0]        inc_prod;
  logic [31:0]              inc;
  logic [31:0]              phase;
  logic signed [15:0]       wave;
  logic [ENV_W-1:0]         env;
  logic [ENV_W-1:0]         amp_env;
  logic signed [MUL_W-1:0]  prod;
  logic signed [15:0]       shaped;
  env_state_t               state;
  logic                     restart;

  assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Constant multiply replaces a per-note division by the sample rate.
  assign inc_prod = PROD_W'(freq) * PROD_W'(INC_K);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) inc <= '0;
    else     inc <= 32'(inc_prod >> INC_SHIFT);
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST)       phase <= '0;
    else if (tick) phase <= restart ? '0 : phase + inc;
  end

  note_env #(
    .ATTACK_RATE  (ATTACK_RATE),
    .RELEASE_RATE (RELEASE_RATE)
  ) u_env (
    .clk     (CLK_50MHZ),
    .rst     (RST),
    .tick    (tick),
    .play    (play),
    .vel     (vel),
    .env     (env),
    .state   (state),
    .restart (restart)
  );

`ifdef NOTE_VOICE_TRIANGLE_EN
  assign wave = (phase[31] ? ~phase[30:15] : phase[30:15]) ^ 16'h8000;
`else
  assign wave = {~phase[31], phase[30:16]};
`endif

  assign amp_env = env & AMP_MASK;
  assign prod    = MUL_W'(wave) * MUL_W'($signed({1'b0, amp_env}));
  assign shaped  = 16'(prod >>> ENV_W);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      sample     <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= tick;
      if (tick) sample <= (state == IDLE) ? 16'sd0 : shaped;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_note_voice.sv
// Self-checking bench for note_voice against a per-tick arithmetic reference model.
module tb_note_voice;

  localparam int unsigned TB_DIV = 16;
  localparam longint      K      = 90072;
  localparam int MS_IDLE = 0, MS_ATTACK = 1, MS_SUSTAIN = 2, MS_RELEASE = 3;

  logic               clk  = 1'b0;
  logic               rst  = 1'b1;
  logic [23:0]        freq = '0;
  logic [6:0]         vel  = '0;
  logic               play = 1'b0;
  logic signed [15:0] sample;
  logic               sample_stb;
  logic               active;

  int     n_checks = 0;
  int     n_errors = 0;
  int     m_state  = MS_IDLE;
  int     m_env    = 0;
  longint m_phase  = 0;

  always #5 clk = ~clk;

  note_voice #(.SAMPLE_DIV(TB_DIV)) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst),
    .freq       (freq),
    .vel        (vel),
    .play       (play),
    .sample     (sample),
    .sample_stb (sample_stb),
    .active     (active)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_inc(input logic [23:0] f);
    return ((longint'(f) * K) >> 10) & 64'hFFFF_FFFF;
  endfunction

  // Sample produced on a tick, from the level and phase held before that tick.
  function automatic int model_sample();
    int w, amp, p;
    if (m_state == MS_IDLE) return 0;
`ifdef NOTE_VOICE_TRIANGLE_EN
    w = int'((m_phase >> 15) & 65535);
    if (m_phase >= 64'd2147483648) w = 65535 - w;
    w = w - 32768;
`else
    w = int'(m_phase >> 16) - 32768;
`endif
    amp = m_env / 128;
    p   = w * amp;
    return (p >= 0) ? p / 128 : -((-p + 127) / 128);
  endfunction

  function automatic void model_tick(input logic p, input logic [6:0] v,
                                     input logic [23:0] f);
    bit on     = p && (v != 0);
    int target = int'(v) * 128;
    if (m_state == MS_IDLE && on) m_phase = 0;
    else                          m_phase = (m_phase + model_inc(f)) % 64'sd4294967296;
    case (m_state)
      MS_IDLE:    if (on) m_state = MS_ATTACK;
      MS_ATTACK:
        if (!on) m_state = MS_RELEASE;
        else if (m_env + 64 >= target) begin m_env = target; m_state = MS_SUSTAIN; end
        else m_env += 64;
      MS_SUSTAIN:
        if (!on) m_state = MS_RELEASE;
        else     m_env   = target;
      default:
        if (on) m_state = MS_ATTACK;
        else if (m_env <= 16) begin m_env = 0; m_state = MS_IDLE; end
        else m_env -= 16;
    endcase
  endfunction

  // Drive inputs, wait (bounded) for the next strobe, then compare with the model.
  task automatic step(input logic p, input logic [6:0] v, input logic [23:0] f,
                      input string tag);
    int n = 0;
    bit stable = 1'b1;
    logic signed [15:0] held;
    int exp_s;
    play = p; vel = v; freq = f;
    held = sample;
    do begin
      @(negedge clk);
      n++;
      if (!sample_stb && sample !== held) stable = 1'b0;
    end while (!sample_stb && n < 4 * TB_DIV);
    exp_s = model_sample();
    model_tick(p, v, f);
    check({tag, ".gap"},    n,         TB_DIV);
    check({tag, ".stable"}, stable,    1);
    check({tag, ".sample"}, sample,    exp_s);
    check({tag, ".active"}, active,    m_state != MS_IDLE);
    check({tag, ".env"},    dut.env,   m_env);
    check({tag, ".phase"},  dut.phase, m_phase);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, ".sample"}, sample,     0);
    check({tag, ".stb"},    sample_stb, 0);
    check({tag, ".active"}, active,     0);
    check({tag, ".inc"},    dut.inc,    0);
    check({tag, ".phase"},  dut.phase,  0);
    check({tag, ".env"},    dut.env,    0);
    m_state = MS_IDLE; m_env = 0; m_phase = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int hold;
    logic signed [15:0] dc;
    logic rp;
    logic [6:0] rv;
    logic [23:0] rf;

    play = 1'b1; vel = 7'd127; freq = 24'd440000;
    apply_reset("por");

    // Note-on at A4: restart tick, then the attack ramp to full level.
    step(1, 127, 440000, "on1");
    check("inc_a4", dut.inc, model_inc(440000));
    step(1, 127, 440000, "on2");
    check("phase_a4", dut.phase, model_inc(440000));
    n = 1;
    while (dut.env !== 14'd16256 && n < 300) begin step(1, 127, 440000, "atk"); n++; end
    check("attack_ticks", n, 254);
    for (int i = 0; i < 3; i++) step(1, 127, 440000, "sus");

    step(0, 127, 440000, "rel_start");
    n = 0;
    while (active && n < 1100) begin step(0, 127, 440000, "rel"); n++; end
    check("release_ticks", n, 1016);

    // Velocity 0 while idle is a note-off: nothing starts.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 440000, "vel0_idle");
      check("vel0_idle_active", active, 0);
      check("vel0_idle_sample", sample, 0);
    end

    // Retrigger during release keeps phase and resumes from the current level.
    step(1, 127, 523251, "re_on");
    n = 0;
    while (dut.env !== 14'd16256 && n < 300) begin step(1, 127, 523251, "re_atk"); n++; end
    step(0, 127, 523251, "re_rel_start");
    for (int i = 0; i < 100; i++) step(0, 127, 523251, "re_rel");
    check("rel100_env", dut.env, 16256 - 1600);
    step(1, 127, 523251, "retrig");
    check("retrig_env", dut.env, 14656);
    n = 0;
    while (dut.env !== 14'd16256 && n < 100) begin step(1, 127, 523251, "retrig_atk"); n++; end
    check("retrig_ticks", n, 25);

    // Velocity dropped to 0 in sustain releases.
    step(1, 0, 523251, "sus_vel0");
    step(1, 0, 523251, "sus_vel0_rel");
    check("vel0_release_env", dut.env, 16256 - 16);
    step(1, 127, 523251, "back_atk");
    step(1, 127, 523251, "back_sus");

    // freq=0 in sustain: phase frozen, output is DC, strobes keep cadence.
    step(1, 127, 0, "dc_start");
    dc = sample;
    for (int i = 0; i < 10; i++) begin
      step(1, 127, 0, "dc");
      check("dc_hold", sample, dc);
    end

    hold = 0;
    rp = 1'b0; rv = '0; rf = '0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        rp = ($urandom_range(0, 3) != 0);
        rv = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        case ($urandom_range(0, 3))
          0:       rf = 24'd0;
          1:       rf = 24'($urandom_range(20000, 16777215));
          2:       rf = 24'hFFFFFF;
          default: rf = 24'($urandom);
        endcase
        hold = $urandom_range(1, 40);
      end
      hold--;
      step(rp, rv, rf, "rnd");
    end

    // Reset asserted in the middle of a sustained note.
    n = 0;
    while (m_state != MS_SUSTAIN && n < 400) begin step(1, 90, 261626, "pre_rst"); n++; end
    step(1, 90, 261626, "pre_rst_sus");
    check("pre_rst_env", dut.env, 90 * 128);
    apply_reset("mid");
    step(1, 90, 261626, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
